// File: rtl/uart_host_pkg.sv
// Shared types and frame constants for the UART host bridge.
// The command byte carries the write flag in bit 7 and the device address in bits 3:0.
package uart_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX_CMD,
      ST_TX_DATA,
      ST_RX_WAIT,
      ST_RX_DATA,
      ST_RSP
   } state_t;

   localparam int   FRAME_LEN    = 10;
   localparam int   CMD_WR_POS   = 7;
   localparam int   CMD_ADDR_LSB = 0;
   localparam int   CMD_ADDR_W   = 4;
   localparam logic IDLE_LINE    = 1'b1;
   localparam logic START_BIT    = 1'b0;
   localparam logic STOP_BIT     = 1'b1;

   function automatic logic [7:0] cmd_byte(input logic wr, input logic [CMD_ADDR_W-1:0] addr);
      logic [7:0] b;
      b = '0;
      b[CMD_WR_POS] = wr;
      b[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
      return b;
   endfunction

endpackage

// File: rtl/uart_host_if.sv
// Host request/response port and serial pins of the UART host bridge.
interface uart_host_if;
   import uart_host_pkg::*;

   // A request transfers on a rising edge where req_valid and req_ready are both 1;
   // req_* must be stable while req_valid is high. rsp_valid is a one-cycle pulse
   // with no backpressure, and rsp_data/rsp_err are meaningful only alongside it.
   logic       req_valid;
   logic       req_ready;
   logic       req_wr;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       xmt_bit;
   logic       rcv_bit;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       busy;
   state_t     state_dbg;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rcv_bit,
      input  req_ready, xmt_bit, rsp_valid, rsp_data, rsp_err, busy, state_dbg
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rcv_bit,
      output req_ready, xmt_bit, rsp_valid, rsp_data, rsp_err, busy, state_dbg
   );

endinterface

// File: rtl/uart_host_frame_tx.sv
// Serializes one byte as start + 8 data bits (LSB first) + stop, each held BIT_CYCLES clocks.
// A load on the same edge as done starts the next frame with no idle gap.
module uart_host_frame_tx
   import uart_host_pkg::*;
#(
   parameter int BIT_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       done,
   output logic       line
);

   localparam logic [7:0] BIT_LAST   = 8'(BIT_CYCLES - 1);
   localparam logic [3:0] FRAME_LAST = 4'(FRAME_LEN - 1);

   logic [FRAME_LEN-1:0] shreg;
   logic [3:0]           bit_cnt;
   logic [7:0]           cyc_cnt;
   logic                 active;

   assign done = active && (bit_cnt == FRAME_LAST) && (cyc_cnt == BIT_LAST);
   assign line = shreg[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg   <= {FRAME_LEN{IDLE_LINE}};
         bit_cnt <= '0;
         cyc_cnt <= '0;
         active  <= 1'b0;
      end else if (load) begin
         shreg   <= {STOP_BIT, data, START_BIT};
         bit_cnt <= '0;
         cyc_cnt <= '0;
         active  <= 1'b1;
      end else if (active) begin
         if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            // Shifting in idle-line ones leaves the line high once the stop bit is gone.
            shreg   <= {IDLE_LINE, shreg[FRAME_LEN-1:1]};
            if (bit_cnt == FRAME_LAST) begin
               active  <= 1'b0;
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else begin
            cyc_cnt <= cyc_cnt + 8'd1;
         end
      end
   end

endmodule

// File: rtl/uart_host.sv
// Bridges single host read/write requests to a byte-oriented serial device:
// sends a command frame (plus a data frame for writes), then waits for the read reply.
module uart_host
   import uart_host_pkg::*;
#(
   parameter int BIT_CYCLES = 1,
   parameter int RX_TIMEOUT = 255
) (
   input  logic  clk,
   input  logic  rst,
   uart_host_if.slave bus
);

   localparam logic [7:0] BIT_LAST     = 8'(BIT_CYCLES - 1);
   localparam logic [7:0] SAMPLE_AT    = 8'(BIT_CYCLES / 2);
   localparam logic [7:0] TIMEOUT_LAST = 8'(RX_TIMEOUT - 1);
   localparam logic [3:0] FRAME_LAST   = 4'(FRAME_LEN - 1);

   state_t     state_q, state_d;
   logic       rdy_en;
   logic       wr_q;
   logic [7:0] wdata_q;
   logic [7:0] wait_cnt;
   logic [7:0] rx_cyc, cyc_base, cyc_next;
   logic [3:0] rx_bit, bit_base, bit_next;
   logic [7:0] rx_sh;
   logic       sync1, sync2;
   logic [7:0] rsp_data_q;
   logic       rsp_err_q;

   logic       hs;
   logic       tx_load, tx_done, tx_line;
   logic [7:0] tx_byte;
   logic       start_seen, timed_out, rx_sample, stop_sample;

   // rdy_en keeps req_ready low while reset is held and rises on the first edge after.
   assign hs            = bus.req_valid && bus.req_ready;
   assign bus.req_ready = rdy_en && (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_RSP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.xmt_bit   = tx_line;
   assign bus.state_dbg = state_q;

   uart_host_frame_tx #(.BIT_CYCLES(BIT_CYCLES)) u_frame_tx (
      .clk  (clk),
      .rst  (rst),
      .load (tx_load),
      .data (tx_byte),
      .done (tx_done),
      .line (tx_line)
   );

   // Receive bit timing is measured from the cycle the start bit is detected (offset 0).
   always_comb begin
      cyc_base = (state_q == ST_RX_DATA) ? rx_cyc : 8'd0;
      bit_base = (state_q == ST_RX_DATA) ? rx_bit : 4'd0;
      cyc_next = cyc_base + 8'd1;
      bit_next = bit_base;
      if (cyc_base == BIT_LAST) begin
         cyc_next = 8'd0;
         bit_next = bit_base + 4'd1;
      end
   end

   assign start_seen  = (state_q == ST_RX_WAIT) && (sync2 == START_BIT);
   assign timed_out   = (state_q == ST_RX_WAIT) && !start_seen && (wait_cnt == TIMEOUT_LAST);
   assign rx_sample   = (state_q == ST_RX_DATA) && (rx_bit != 4'd0) && (rx_cyc == SAMPLE_AT);
   assign stop_sample = rx_sample && (rx_bit == FRAME_LAST);

   always_comb begin
      state_d = state_q;
      tx_load = 1'b0;
      tx_byte = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (hs) begin
               state_d = ST_TX_CMD;
               tx_load = 1'b1;
               tx_byte = cmd_byte(bus.req_wr, bus.req_addr);
            end
         end
         ST_TX_CMD: begin
            if (tx_done) begin
               if (wr_q) begin
                  state_d = ST_TX_DATA;
                  tx_load = 1'b1;
               end else begin
                  state_d = ST_RX_WAIT;
               end
            end
         end
         ST_TX_DATA: if (tx_done) state_d = ST_RSP;
         ST_RX_WAIT: begin
            if (start_seen)     state_d = ST_RX_DATA;
            else if (timed_out) state_d = ST_RSP;
         end
         ST_RX_DATA: if (stop_sample) state_d = ST_RSP;
         ST_RSP:     state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         rdy_en  <= 1'b0;
      end else begin
         state_q <= state_d;
         rdy_en  <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         wait_cnt   <= '0;
         rx_cyc     <= '0;
         rx_bit     <= '0;
         rx_sh      <= '0;
         sync1      <= IDLE_LINE;
         sync2      <= IDLE_LINE;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         sync1 <= bus.rcv_bit;
         sync2 <= sync1;
         wait_cnt <= (state_q == ST_RX_WAIT) ? wait_cnt + 8'd1 : 8'd0;
         if ((state_q == ST_RX_WAIT) || (state_q == ST_RX_DATA)) begin
            rx_cyc <= cyc_next;
            rx_bit <= bit_next;
         end else begin
            rx_cyc <= '0;
            rx_bit <= '0;
         end
         if (hs) begin
            wr_q       <= bus.req_wr;
            wdata_q    <= bus.req_wdata;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
         end
         if (rx_sample && !stop_sample) rx_sh <= {sync2, rx_sh[7:1]};
         if (stop_sample) begin
            rsp_data_q <= rx_sh;
            rsp_err_q  <= (sync2 != STOP_BIT);
         end
         if (timed_out) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
         end
      end
   end

endmodule

// File: doc/uart_host.md
UART_HOST -- requirements
Module: uart_host

Interface
REQ-001 SHALL have parameter BIT_CYCLES, default 1, meaning clocks per serial bit time (legal values 1..255).
REQ-002 SHALL have parameter RX_TIMEOUT, default 255, meaning the maximum number of RX_WAIT cycles before a read is abandoned.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a host request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port req_wr, input, 1 bit: 1 = memory write, 0 = memory read.
REQ-008 SHALL have port req_addr, input, 4 bits: device memory address.
REQ-009 SHALL have port req_wdata, input, 8 bits: write data.
REQ-010 SHALL have port xmt_bit, output, 1 bit: serial line driven to the device receive pin.
REQ-011 SHALL have port rcv_bit, input, 1 bit: serial line from the device transmit pin.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse; there is no backpressure.
REQ-013 SHALL have port rsp_data, output, 8 bits: the read byte (0x00 for writes).
REQ-014 SHALL have port rsp_err, output, 1 bit: timeout or framing error; valid with rsp_valid.
REQ-015 SHALL have port busy, output, 1 bit: the state is not IDLE.

Function
REQ-016 SHALL use the serial frame: start 0, 8 data bits LSB first, stop 1; each bit is held for BIT_CYCLES clocks; the idle line is 1.
REQ-017 SHALL form the command byte as {req_wr, 3'b000, req_addr}.
REQ-018 SHALL capture the request on the handshake cycle T, when req_valid and req_ready are both 1; req_ready SHALL be 1 only in IDLE.
REQ-019 SHALL implement states IDLE, TX_CMD, TX_DATA, RX_WAIT, RX_DATA, RSP.
- IDLE -> TX_CMD on handshake.
- TX_CMD -> TX_DATA if the request is a write, otherwise -> RX_WAIT.
- TX_DATA -> RSP.
- RX_WAIT -> RX_DATA on a detected start bit, or -> RSP on timeout.
- RX_DATA -> RSP after the stop bit is sampled.
- RSP -> IDLE.
REQ-020 SHALL begin the command start bit at T+1; with BIT_CYCLES=1 the command frame occupies T+1..T+10.
REQ-021 SHALL send the write data frame back-to-back, at T+11..T+20 (BIT_CYCLES=1), and assert rsp_valid at T+21 with rsp_data=0x00 and rsp_err=0.
REQ-022 SHALL pass rcv_bit through a 2-flop synchronizer; a start bit is a synchronized 0 seen in RX_WAIT.
REQ-023 SHALL sample data and stop bits at offset BIT_CYCLES/2 (integer division) within each bit time, counted from start detection.
REQ-024 SHALL assert rsp_valid the cycle after the stop bit is sampled, with rsp_data equal to the received byte; rsp_err=1 iff the stop bit is 0.
REQ-025 SHALL count cycles in RX_WAIT with an 8-bit counter; on reaching RX_TIMEOUT it SHALL go to RSP with rsp_err=1 and rsp_data=0x00.
REQ-026 SHALL ignore rcv_bit outside RX_WAIT and RX_DATA.
REQ-027 SHALL ignore req_valid while busy, and SHALL NOT re-sample req_* fields after the handshake.
REQ-028 SHALL hold xmt_bit at 1 in all states except during transmitted frames.

Reset
REQ-029 SHALL, during rst, immediately force: state IDLE, xmt_bit=1, req_ready=0, rsp_valid=0, rsp_data=0x00, rsp_err=0, busy=0, all counters 0, synchronizer flops 1.
REQ-030 SHALL assert req_ready on the first clock edge after rst deasserts; a frame interrupted by reset SHALL NOT resume.

Structure
REQ-031 SHALL place the state enum, the frame length (10), the command-byte field positions and the idle-line value in package uart_host_pkg.
REQ-032 SHALL instantiate one sub-module, uart_host_frame_tx: a shift register plus bit counter that serializes one byte; it has load and done handshakes and is used for both the command and data frames.

Verification
REQ-033 SHALL cover: write addr=5, data=0xA5, BIT_CYCLES=1 -> xmt_bit is 0,1,0,1,0,0,0,0,1,1 then 0,1,0,1,0,0,1,0,1,1; rsp_valid at T+21 with rsp_err=0.
REQ-034 SHALL cover: read addr=3, device returns a frame carrying 0x3C -> command frame for 0x03 is sent; rsp_valid with rsp_data=0x3C and rsp_err=0.
REQ-035 SHALL cover: read with rcv_bit held at 1 and RX_TIMEOUT=20 -> rsp_valid with rsp_err=1 and rsp_data=0x00, exactly 20 cycles after RX_WAIT is entered.
REQ-036 SHALL cover: read response 0x81 with stop bit 0 -> rsp_valid with rsp_data=0x81 and rsp_err=1.
REQ-037 SHALL cover: rst asserted mid-frame at T+5 -> xmt_bit=1 and rsp_valid=0 at once, and req_ready=1 on the first edge after release.
REQ-038 SHALL cover: BIT_CYCLES=4 with req_valid held high through a write -> each bit lasts 4 cycles, a second handshake occurs only after rsp_valid, and no duplicate frame is sent.
